// File: rtl/cms_axis_trace_receiver.sv
// cms_axis_trace_receiver
// AXI-Stream slave that buffers 512-bit trace packets from the continuous
// monitoring system in a DEPTH-entry FIFO. It presents the decoded pc, instr
// and perf counter fields on a valid/ready port. It also checks frame
// boundaries against tlast_interval and keeps saturating status counters.
// Optional feature macro: CMS_RX_DROP_ON_FULL_EN. When it is defined, tready
// follows en alone and beats that arrive while the FIFO is full are dropped
// and counted in overflow_count. Otherwise a full FIFO backpressures and
// overflow_count is tied to zero.
module cms_axis_trace_receiver #(
    parameter int DEPTH             = 16,
    parameter int AXI_DATA_WIDTH    = 512,
    parameter int XLEN              = 64,
    parameter int NO_OF_PERF_EVENTS = 37,
    parameter int PERF_CNT_WIDTH    = 7
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        flush,
    input  logic                                        S_AXIS_tvalid,
    output logic                                        S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0]                   S_AXIS_tdata,
    input  logic                                        S_AXIS_tlast,
    input  logic [31:0]                                 tlast_interval,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [XLEN-1:0]                             out_pc,
    output logic [31:0]                                 out_instr,
    output logic [NO_OF_PERF_EVENTS*PERF_CNT_WIDTH-1:0] out_perf_counters,
    output logic                                        out_last,
    output logic [31:0]                                 beats_received,
    output logic [31:0]                                 frames_received,
    output logic [15:0]                                 frame_errors,
    output logic                                        frame_err_sticky,
    output logic [15:0]                                 overflow_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PERF_W = NO_OF_PERF_EVENTS * PERF_CNT_WIDTH;
    localparam int PAY_W  = XLEN + 32 + PERF_W;
    localparam int ENT_W  = PAY_W + 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             beat_fire;
    logic             push;
    logic             pop;
    logic [31:0]      beat_idx;
    logic [32:0]      idx;
    logic             interval_hit;
    logic             frame_err;
    logic [ENT_W-1:0] head;
    logic             unused_reserved;

    // The reserved upper tdata bits carry nothing this block consumes.
    assign unused_reserved = ^S_AXIS_tdata[AXI_DATA_WIDTH-1:PAY_W];

    assign full      = (count == FULL_COUNT);
    assign out_valid = (count != '0);

`ifdef CMS_RX_DROP_ON_FULL_EN
    assign S_AXIS_tready = ~rst & en;
`else
    assign S_AXIS_tready = ~rst & en & ~full;
`endif

    assign beat_fire = S_AXIS_tvalid & S_AXIS_tready;
    assign push      = beat_fire & ~full;
    assign pop       = out_valid & out_ready;

    // idx is one bit wider so that a saturated beat_idx cannot wrap to zero
    // and falsely match the interval.
    assign idx          = {1'b0, beat_idx} + 33'd1;
    assign interval_hit = (idx == {1'b0, tlast_interval});
    assign frame_err    = beat_fire & (tlast_interval != '0) & (S_AXIS_tlast ^ interval_hit);

    assign head              = mem[rd_ptr];
    assign out_pc            = head[XLEN-1:0];
    assign out_instr         = head[XLEN+31:XLEN];
    assign out_perf_counters = head[PAY_W-1:XLEN+32];
    assign out_last          = head[ENT_W-1];

    // Payload storage: only the meaningful low bits and tlast are kept.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {S_AXIS_tlast, S_AXIS_tdata[PAY_W-1:0]};
        end
    end

    // FIFO pointers and fill level. Flush takes priority over any push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame position tracking and framing error accounting.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            beat_idx         <= '0;
            frame_errors     <= '0;
            frame_err_sticky <= 1'b0;
        end else begin
            if (beat_fire) begin
                if (S_AXIS_tlast)  beat_idx <= '0;
                else if (idx[32])  beat_idx <= '1;
                else               beat_idx <= idx[31:0];
            end
            if (frame_err) begin
                frame_err_sticky <= 1'b1;
                if (frame_errors != '1) frame_errors <= frame_errors + 16'd1;
            end
        end
    end

    // Beat and frame counters cover only beats that were stored.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            beats_received  <= '0;
            frames_received <= '0;
        end else if (push) begin
            if (beats_received != '1) beats_received <= beats_received + 32'd1;
            if (S_AXIS_tlast && frames_received != '1) frames_received <= frames_received + 32'd1;
        end
    end

`ifdef CMS_RX_DROP_ON_FULL_EN
    // Count beats discarded because the FIFO was full on arrival.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflow_count <= '0;
        end else if (beat_fire && full && overflow_count != '1) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end
`else
    assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_cms_axis_trace_receiver.sv
// tb_cms_axis_trace_receiver
// The driver pushes the expected decode of every stored beat into a queue.
// A separate monitor pops and compares each entry when the DUT hands it over.
// Directed sequences cover latency, backpressure, framing, flush and reset.
// Also honours CMS_RX_DROP_ON_FULL_EN.
module tb_cms_axis_trace_receiver;

    typedef struct {
        logic [63:0]  pc;
        logic [31:0]  instr;
        logic [258:0] perf;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         flush;
    logic         S_AXIS_tvalid;
    logic         S_AXIS_tready;
    logic [511:0] S_AXIS_tdata;
    logic         S_AXIS_tlast;
    logic [31:0]  tlast_interval;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_pc;
    logic [31:0]  out_instr;
    logic [258:0] out_perf_counters;
    logic         out_last;
    logic [31:0]  beats_received;
    logic [31:0]  frames_received;
    logic [15:0]  frame_errors;
    logic         frame_err_sticky;
    logic [15:0]  overflow_count;

    exp_t expQ[$];
    exp_t monEntry;
    int   numChecks = 0;
    int   numErrors = 0;
    int   waited;

    cms_axis_trace_receiver dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .flush             (flush),
        .S_AXIS_tvalid     (S_AXIS_tvalid),
        .S_AXIS_tready     (S_AXIS_tready),
        .S_AXIS_tdata      (S_AXIS_tdata),
        .S_AXIS_tlast      (S_AXIS_tlast),
        .tlast_interval    (tlast_interval),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_instr         (out_instr),
        .out_perf_counters (out_perf_counters),
        .out_last          (out_last),
        .beats_received    (beats_received),
        .frames_received   (frames_received),
        .frame_errors      (frame_errors),
        .frame_err_sticky  (frame_err_sticky),
        .overflow_count    (overflow_count)
    );

    // 100 MHz style free-running clock.
    always #5 clk = ~clk;

    // Perf vector with field 36 set to perf and field 0 set to its complement.
    function automatic logic [258:0] makePerf(input logic [6:0] perf);
        logic [258:0] v;
        v = '0;
        v[252 +: 7] = perf;
        v[0 +: 7]   = ~perf;
        return v;
    endfunction

    // Reserved bits are driven to ones so that any leak into outputs shows up.
    function automatic logic [511:0] makeData(input logic [63:0] pc, input logic [31:0] instr,
                                              input logic [6:0] perf);
        logic [511:0] d;
        d = '1;
        d[354:0] = {makePerf(perf), instr, pc};
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [258:0] act, input logic [258:0] req);
        numChecks++;
        if (act !== req) begin
            numErrors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one beat starting at posedge+1 and hold it until it is accepted.
    // Returns at posedge+1 after the accepting edge with tvalid low.
    task automatic applyStimulus(input logic [63:0] pc, input logic [31:0] instr,
                                 input logic [6:0] perf, input logic last,
                                 input bit store, output int cyclesWaited);
        exp_t e;
        bit   accepted;
        S_AXIS_tdata  = makeData(pc, instr, perf);
        S_AXIS_tlast  = last;
        S_AXIS_tvalid = 1'b1;
        accepted      = 1'b0;
        cyclesWaited  = 0;
        while (!accepted && cyclesWaited < 40) begin
            @(negedge clk);
            if (S_AXIS_tready) begin
                accepted = 1'b1;
                if (store) begin
                    e.pc = pc; e.instr = instr; e.perf = makePerf(perf); e.last = last;
                    expQ.push_back(e);
                end
            end else begin
                cyclesWaited++;
            end
            @(posedge clk); #1;
        end
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        if (!accepted) begin
            numChecks++;
            numErrors++;
            $display("[TB] FAIL accept_timeout pc actual=none required=%0h", pc);
        end
    endtask

    task automatic doFlush();
        flush = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        out_ready = 1'b1;
        cyc = 0;
        while (out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("drain_empty", out_valid, 1'b0);
        checkOutput("queue_left", 259'(expQ.size()), 259'd0);
    endtask

    // Monitor: compare the head entry each time it is consumed.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                numChecks++;
                numErrors++;
                $display("[TB] FAIL unexpected_output pc actual=%0h required=none", out_pc);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("out_pc", out_pc, monEntry.pc);
                checkOutput("out_instr", out_instr, monEntry.instr);
                checkOutput("out_perf", out_perf_counters, monEntry.perf);
                checkOutput("out_last", out_last, monEntry.last);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; S_AXIS_tlast = 1'b0;
        tlast_interval = '0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("tready_in_reset", S_AXIS_tready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_beats", beats_received, 32'd0);
        checkOutput("rst_frames", frames_received, 32'd0);
        checkOutput("rst_errors", frame_errors, 16'd0);
        checkOutput("rst_sticky", frame_err_sticky, 1'b0);
        checkOutput("rst_overflow", overflow_count, 16'd0);
        checkOutput("tready_after_rst", S_AXIS_tready, 1'b1);
        @(posedge clk); #1;

        // Three beats, one cycle latency each
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(64'h1000 + 64'(4 * i), 32'h13 + 32'(i), 7'(i), 1'b0, 1'b1, waited);
            checkOutput("lat_valid", out_valid, 1'b1);
            checkOutput("lat_pc", out_pc, 64'h1000 + 64'(4 * i));
        end
        checkOutput("beats_3", beats_received, 32'd3);
        @(posedge clk); #1;
        checkOutput("idle_valid", out_valid, 1'b0);

`ifndef CMS_RX_DROP_ON_FULL_EN
        // Backpressure: fill 16, hold beat 17, release one slot at a time
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(64'h2000 + 64'(4 * i), 32'h200 + 32'(i), 7'(i + 16), 1'b0, 1'b1, waited);
        end
        S_AXIS_tdata  = makeData(64'h2040, 32'h210, 7'd32);
        S_AXIS_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("tready_full", S_AXIS_tready, 1'b0);
            @(posedge clk); #1;
        end
        checkOutput("beats_at_full", beats_received, 32'd19);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("tready_full_pop", S_AXIS_tready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(64'h2040, 32'h210, 7'd32, 1'b0, 1'b1, waited);
        checkOutput("tready_after_pop", 259'(waited), 259'd0);
        for (int i = 17; i < 20; i++) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            applyStimulus(64'h2000 + 64'(4 * i), 32'h200 + 32'(i), 7'(i + 16), 1'b0, 1'b1, waited);
        end
        checkOutput("beats_23", beats_received, 32'd23);
        checkOutput("overflow_zero", overflow_count, 16'd0);
        drain();
`else
        // Drop-on-full: 18 beats, the last two discarded
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(64'h2000 + 64'(4 * i), 32'h200 + 32'(i), 7'(i + 16), 1'b0, i < 16, waited);
            checkOutput("tready_drop", 259'(waited), 259'd0);
        end
        checkOutput("overflow_2", overflow_count, 16'd2);
        checkOutput("beats_19", beats_received, 32'd19);
        drain();
`endif

        // Framing: clean frames, then a short frame
        doFlush();
        tlast_interval = 32'd4;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(64'h3000 + 64'(i), 32'h300, 7'd1, (i % 4) == 0, 1'b1, waited);
        end
        checkOutput("frames_2", frames_received, 32'd2);
        checkOutput("errors_0", frame_errors, 16'd0);
        checkOutput("sticky_0", frame_err_sticky, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(64'h3100 + 64'(i), 32'h310, 7'd2, i == 3, 1'b1, waited);
        end
        checkOutput("errors_short", frame_errors, 16'd1);
        checkOutput("sticky_short", frame_err_sticky, 1'b1);
        checkOutput("frames_3", frames_received, 32'd3);

        // Framing: missing tlast, then late tlast, then a clean frame
        doFlush();
        checkOutput("flush_sticky", frame_err_sticky, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(64'h4000 + 64'(i), 32'h400, 7'd3, i == 6, 1'b1, waited);
            if (i == 4) checkOutput("errors_missing", frame_errors, 16'd1);
        end
        checkOutput("errors_late", frame_errors, 16'd2);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(64'h4100 + 64'(i), 32'h410, 7'd4, i == 4, 1'b1, waited);
        end
        checkOutput("errors_realigned", frame_errors, 16'd2);
        checkOutput("frames_late", frames_received, 32'd2);

        // Perf field 36, enable gating, flush racing a beat
        doFlush();
        tlast_interval = 32'd0;
        applyStimulus(64'h5000, 32'h500, 7'h55, 1'b1, 1'b1, waited);
        checkOutput("perf_k36", out_perf_counters[258:252], 7'h55);
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(64'h5004, 32'h501, 7'h11, 1'b0, 1'b1, waited);
        applyStimulus(64'h5008, 32'h502, 7'h22, 1'b0, 1'b1, waited);
        en = 1'b0;
        S_AXIS_tvalid = 1'b1;
        @(negedge clk);
        checkOutput("tready_en_low", S_AXIS_tready, 1'b0);
        @(posedge clk); #1;
        en = 1'b1;
        S_AXIS_tdata = makeData(64'h500c, 32'h503, 7'h33);
        doFlush();
        S_AXIS_tvalid = 1'b0;
        checkOutput("flush_valid", out_valid, 1'b0);
        checkOutput("flush_beats", beats_received, 32'd0);
        checkOutput("flush_frames", frames_received, 32'd0);
        checkOutput("flush_errors", frame_errors, 16'd0);

        // Reset mid-frame discards partial frame state
        tlast_interval = 32'd4;
        out_ready = 1'b1;
        applyStimulus(64'h6000, 32'h600, 7'd5, 1'b0, 1'b1, waited);
        applyStimulus(64'h6001, 32'h601, 7'd6, 1'b0, 1'b1, waited);
        rst = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(64'h6100 + 64'(i), 32'h610, 7'd7, i == 4, 1'b1, waited);
        end
        checkOutput("rst_frame_errors", frame_errors, 16'd0);
        checkOutput("rst_frame_count", frames_received, 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
        $finish;
    end

endmodule
